mem_array_ctrl: RTL and testbench

MEM_ARRAY_CTRL -- requirements
Module: mem_array_ctrl

---
 rtl/mem_array_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_array_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_array_ctrl.sv
// Word-addressed memory array with byte-enable writes, a fixed-latency read pipeline
// and a hardware sequencer that zeroes every word after reset or on a clear request.
module mem_array_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AI = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   CLR_LAST = CW'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     clr_ptr;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic          accept, oor, wr_acc, rd_acc;
    logic [AI-1:0] req_idx, clr_idx;

    assign accept  = req_valid & req_ready;
    assign oor     = {1'b0, req_addr} >= DEPTH_C;
    assign wr_acc  = accept & req_write & ~oor & (|req_be);
    assign rd_acc  = accept & ~req_write;
    assign req_idx = AI'(req_addr);
    assign clr_idx = AI'(clr_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                clr_ptr <= (clr_ptr == CLR_LAST) ? '0 : clr_ptr + CW'(1);
            else
                clr_ptr <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        req_ready = 1'b0;
        case (state)
            INIT: begin
                busy = 1'b1;
                if (clr_ptr == CLR_LAST)
                    state_nxt = RUN;
            end
            RUN: begin
                req_ready = 1'b1;
                if (clear)
                    state_nxt = INIT;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Array contents are never reset; the INIT sweep is what zeroes them.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_idx] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++)
                if (req_be[i])
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
    end

    // Stage p0: array read captured on the acceptance edge
    logic              vld_p0, err_p0;
    logic [DATA_W-1:0] data_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            err_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= rd_acc;
            err_p0 <= rd_acc & oor;
            if (rd_acc)
                data_p0 <= oor ? '0 : mem[req_idx];
        end
    end

    // Stage p1: optional extra delay for RD_LAT == 2
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              vld_p1, err_p1;
            logic [DATA_W-1:0] data_p1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p1  <= 1'b0;
                    err_p1  <= 1'b0;
                    data_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    err_p1 <= err_p0;
                    if (vld_p0)
                        data_p1 <= data_p0;
                end
            end

            assign rsp_valid = vld_p1;
            assign rsp_err   = err_p1;
            assign rsp_rdata = data_p1;
        end else begin : g_lat1
            assign rsp_valid = vld_p0;
            assign rsp_err   = err_p0;
            assign rsp_rdata = data_p0;
        end
    endgenerate

endmodule

// File: tb/tb_mem_array_ctrl.sv
// Scoreboard bench for mem_array_ctrl: a reference memory model predicts every read
// response (data, error flag, arrival cycle) and the monitor checks them in order.
module tb_mem_array_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              clear = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [3:0]        req_be = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    mem_array_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              e;
        int                due;
    } exp_t;

    exp_t              sbq[$];
    logic [DATA_W-1:0] mdl [0:255];
    int                cyc = 0;
    int                nvec = 0;
    int                nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(x.d));
                chk("rsp_err", 64'(rsp_err), 64'(x.e));
                chk("rsp_cycle", 64'(cyc), 64'(x.due));
            end
        end
    end

    task automatic zero_model();
        for (int i = 0; i < 256; i++) mdl[i] = '0;
    endtask

    // Drive one request at the negedge; it is sampled on the following posedge.
    task automatic drive(input bit v, input bit w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [3:0] be,
                         input bit clr, input bit track);
        exp_t x;
        @(negedge clk);
        req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        clear = clr;
        if (req_ready === 1'b1) begin
            if (v && !w && track) begin
                x.d   = (int'(a) < DEPTH) ? mdl[a] : '0;
                x.e   = (int'(a) >= DEPTH);
                x.due = cyc + RD_LAT;
                sbq.push_back(x);
            end
            if (v && w && int'(a) < DEPTH)
                for (int i = 0; i < 4; i++)
                    if (be[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
            if (clr) zero_model();
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        drive(1'b1, 1'b0, a, '0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [3:0] be);
        drive(1'b1, 1'b1, a, d, be, 1'b0, 1'b0);
    endtask

    // Counts busy cycles from the current negedge until req_ready rises.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < DEPTH + 20) begin
            if (busy === 1'b1) n++;
            @(negedge clk);
        end
        chk(tag, 64'(n), 64'(DEPTH));
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < RD_LAT + 2; i++) idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        zero_model();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_ready("init_len");

        // Freshly cleared array reads zero at both ends
        rd(8'd199); rd(8'd0);
        drain();

        // Byte-enable merge, read immediately after write
        wr(8'd5, 32'hAABBCCDD, 4'b1111);
        wr(8'd5, 32'h11223344, 4'b0101);
        rd(8'd5);
        drain();
        chk("be_merge_model", 64'(mdl[5]), 64'hAA22CC44);

        // Back-to-back reads must come out on consecutive cycles, in order
        for (int i = 1; i <= 4; i++) wr(8'(i), 32'h1000_0000 * i + 32'(i * 17), 4'hF);
        for (int i = 1; i <= 4; i++) rd(8'(i));
        drain();

        // Out-of-range write is dropped, out-of-range read flags an error
        wr(8'd199, 32'hCAFE0199, 4'hF);
        wr(8'd210, 32'h0000005A, 4'hF);
        rd(8'd210);
        rd(8'd199);
        rd(8'd255);
        wr(8'd6, 32'h66666666, 4'hF);
        wr(8'd6, 32'hDEADBEEF, 4'h0);
        rd(8'd6);
        drain();

        // Clear during traffic: same-edge read sees pre-clear data
        wr(8'd3, 32'h00000077, 4'hF);
        drive(1'b1, 1'b0, 8'd3, '0, 4'h0, 1'b1, 1'b1);
        idle();
        wait_ready("clear_len");
        rd(8'd3);
        rd(8'd5);
        drain();

        // Reset one cycle after a read is accepted: response must never appear
        wr(8'd7, 32'h12345678, 4'hF);
        drive(1'b1, 1'b0, 8'd7, '0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        zero_model();
        repeat (3) @(negedge clk);
        check_reset_outputs("midread_reset");
        rst_n = 1'b1;
        wait_ready("reinit_len");
        rd(8'd7);
        rd(8'd199);
        drain();

        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
